qos_egress_reader: RTL and testbench

Reader end of the QoS egress stage. It drains the four per-class output FIFOs by issuing their pop strobes, and merges the popped 12-bit words into one valid/ready stream tagged with the source class. Arbitration between classes is round-robin. A 2-entry output buffer absorbs sink back-pressure. Per-class read counters are exposed for the statistics logic.

---
 rtl/qos_egress_reader.sv | 168 ++++++++++++++++
 tb/tb_qos_egress_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_egress_reader.sv
// Drains four class FIFOs into one tagged valid/ready stream through a BUF_DEPTH-entry credit-limited buffer.
// Round-robin arbitration by default; define QOS_RD_STRICT_PRIO_EN for strict priority (class 0 highest).
module qos_egress_reader #(
  parameter int DATA_W    = 12,
  parameter int CNT_W     = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_class,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rd_count0,
  output logic [CNT_W-1:0]  rd_count1,
  output logic [CNT_W-1:0]  rd_count2,
  output logic [CNT_W-1:0]  rd_count3,
  output logic              idle_out
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              cap_vld_q, cap_vld_d;
  logic [1:0]        cap_cls_q, cap_cls_d;
  logic [DATA_W-1:0] buf_dat_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_dat_d [BUF_DEPTH];
  logic [1:0]        buf_cls_q [BUF_DEPTH];
  logic [1:0]        buf_cls_d [BUF_DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q [4];
  logic [CNT_W-1:0]  rd_cnt_d [4];
`ifndef QOS_RD_STRICT_PRIO_EN
  logic [1:0]        rr_q, rr_d;
`endif

  logic              deq, credit, grant_vld;
  logic [1:0]        grant;
  logic [CW:0]       occ;
  logic [DATA_W-1:0] cap_dat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant     = 2'd0;
`ifdef QOS_RD_STRICT_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      idx = 2'(i);
      if (!fifo_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
`else
    // Descending scan so the class nearest after the pointer wins; the pointer's own class is last.
    for (int i = 4; i >= 1; i--) begin
      idx = rr_q + 2'(i);
      if (!fifo_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
`endif
  end

  always_comb begin
    deq = out_valid && out_ready;
    // Words popped or buffered but not yet accepted; this cycle's output handshake frees a slot.
    occ    = (CW+1)'(cnt_q) + (CW+1)'(cap_vld_q) - (CW+1)'(deq);
    credit = occ < (CW+1)'(BUF_DEPTH);
    pop    = '0;
    if (state_q == RUN && enable && grant_vld && credit) pop[grant] = 1'b1;

    case (cap_cls_q)
      2'd0:    cap_dat = fifo_data0;
      2'd1:    cap_dat = fifo_data1;
      2'd2:    cap_dat = fifo_data2;
      default: cap_dat = fifo_data3;
    endcase

    buf_dat_d = buf_dat_q;
    buf_cls_d = buf_cls_q;
    tail_d    = tail_q;
    head_d    = deq ? ptr_inc(head_q) : head_q;
    if (cap_vld_q) begin
      buf_dat_d[tail_q] = cap_dat;
      buf_cls_d[tail_q] = cap_cls_q;
      tail_d            = ptr_inc(tail_q);
    end
    cnt_d     = cnt_q + CW'(cap_vld_q) - CW'(deq);
    cap_vld_d = |pop;
    cap_cls_d = grant;
`ifndef QOS_RD_STRICT_PRIO_EN
    rr_d = (|pop) ? grant : rr_q;
`endif
    for (int k = 0; k < 4; k++) rd_cnt_d[k] = rd_cnt_q[k] + CNT_W'(pop[k]);

    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !(&fifo_empty)) state_d = RUN;
      RUN: begin
        if (!enable) state_d = DRAIN;
        else if (&fifo_empty && cnt_q == '0 && !cap_vld_q) state_d = IDLE;
      end
      DRAIN: begin
        if (enable) state_d = RUN;
        else if (cnt_q == '0 && !cap_vld_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cap_vld_q <= 1'b0;
      cap_cls_q <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_dat_q[i] <= '0;
        buf_cls_q[i] <= 2'd0;
      end
      for (int k = 0; k < 4; k++) rd_cnt_q[k] <= '0;
`ifndef QOS_RD_STRICT_PRIO_EN
      rr_q <= 2'd3;
`endif
    end else begin
      state_q   <= state_d;
      cap_vld_q <= cap_vld_d;
      cap_cls_q <= cap_cls_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      buf_dat_q <= buf_dat_d;
      buf_cls_q <= buf_cls_d;
      rd_cnt_q  <= rd_cnt_d;
`ifndef QOS_RD_STRICT_PRIO_EN
      rr_q <= rr_d;
`endif
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = buf_dat_q[head_q];
  assign out_class = buf_cls_q[head_q];
  assign idle_out  = (state_q == IDLE);
  assign rd_count0 = rd_cnt_q[0];
  assign rd_count1 = rd_cnt_q[1];
  assign rd_count2 = rd_cnt_q[2];
  assign rd_count3 = rd_cnt_q[3];
endmodule

// File: tb/tb_qos_egress_reader.sv
// Randomized and directed bench for qos_egress_reader against a queue-based reference model.
module tb_qos_egress_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  fifo_empty;
  logic [11:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
  logic [3:0]  pop;
  logic [11:0] out_data;
  logic [1:0]  out_class;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rd_count0, rd_count1, rd_count2, rd_count3;
  logic        idle_out;

  qos_egress_reader #(.DATA_W(12), .CNT_W(5), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data0(fifo_data0), .fifo_data1(fifo_data1), .fifo_data2(fifo_data2), .fifo_data3(fifo_data3),
    .pop(pop), .out_data(out_data), .out_class(out_class), .out_valid(out_valid), .out_ready(out_ready),
    .rd_count0(rd_count0), .rd_count1(rd_count1), .rd_count2(rd_count2), .rd_count3(rd_count3),
    .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  typedef logic [11:0] word_q_t [$];
  typedef struct { logic [1:0] cls; logic [11:0] dat; int cyc; } exp_t;

  word_q_t     fq [4];
  exp_t        exp_q [$];
  logic [11:0] rdata [4];
  bit   [3:0]  pop_last;
  int          m_state;   // 0 idle, 1 run, 2 drain
  int          m_cnt [4];
`ifndef QOS_RD_STRICT_PRIO_EN
  int          m_ptr;
`endif
  int          cyc;
  int          passed, total;
  logic [3:0]  last_pop;
  logic        last_ov;
  logic [11:0] last_od;
  logic [1:0]  last_oc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [11:0] word(input int k, input int i);
    return 12'((k + 1) * 256 + i);
  endfunction

  task automatic step(input logic en, input logic rdy);
    logic [3:0] exp_pop;
    bit exp_ov, dq, any;
    int outst, g, j;
    @(negedge clk);
    enable    = en;
    out_ready = rdy;
    for (int k = 0; k < 4; k++) fifo_empty[k] = (fq[k].size() == 0);
    fifo_data0 = pop_last[0] ? rdata[0] : 12'($urandom);
    fifo_data1 = pop_last[1] ? rdata[1] : 12'($urandom);
    fifo_data2 = pop_last[2] ? rdata[2] : 12'($urandom);
    fifo_data3 = pop_last[3] ? rdata[3] : 12'($urandom);
    #4;
    outst  = exp_q.size();
    exp_ov = 1'b0;
    if (outst > 0) exp_ov = (exp_q[0].cyc + 2 <= cyc);
    dq  = exp_ov && rdy;
    any = 1'b0;
    for (int k = 0; k < 4; k++) if (fq[k].size() > 0) any = 1'b1;
    exp_pop = '0;
    g = -1;
    if (m_state == 1 && en && any && (outst - (dq ? 1 : 0)) < 2) begin
`ifdef QOS_RD_STRICT_PRIO_EN
      for (int i = 0; i < 4; i++) if (g < 0 && fq[i].size() > 0) g = i;
`else
      j = m_ptr;
      for (int i = 0; i < 4; i++) begin
        j = (j + 1) % 4;
        if (g < 0 && fq[j].size() > 0) g = j;
      end
`endif
      exp_pop[g] = 1'b1;
    end
    last_pop = pop; last_ov = out_valid; last_od = out_data; last_oc = out_class;
    check("pop", 32'(pop), 32'(exp_pop));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_data", 32'(out_data), 32'(exp_q[0].dat));
      check("out_class", 32'(out_class), 32'(exp_q[0].cls));
    end
    check("idle_out", 32'(idle_out), 32'(m_state == 0));
    check("rd_count0", 32'(rd_count0), 32'(m_cnt[0]));
    check("rd_count1", 32'(rd_count1), 32'(m_cnt[1]));
    check("rd_count2", 32'(rd_count2), 32'(m_cnt[2]));
    check("rd_count3", 32'(rd_count3), 32'(m_cnt[3]));
    // Effects of the coming clock edge on the environment and the model.
    if (dq) void'(exp_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      pop_last[k] = 1'b0;
      if (pop[k] && fq[k].size() > 0) begin
        rdata[k] = fq[k].pop_front();
        exp_q.push_back('{cls: 2'(k), dat: rdata[k], cyc: cyc});
        pop_last[k] = 1'b1;
        m_cnt[k] = (m_cnt[k] + 1) % 32;
`ifndef QOS_RD_STRICT_PRIO_EN
        m_ptr = k;
`endif
      end
    end
    case (m_state)
      0: if (en && any) m_state = 1;
      1: if (!en) m_state = 2; else if (!any && outst == 0) m_state = 0;
      default: if (en) m_state = 1; else if (outst == 0) m_state = 0;
    endcase
    cyc++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    pop_last = '0;
    m_state  = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
`ifndef QOS_RD_STRICT_PRIO_EN
    m_ptr = 3;
`endif
  endtask

  task automatic do_reset(input bit flush);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd_count", 32'({rd_count0, rd_count1, rd_count2, rd_count3}), 32'd0);
    check("rst_idle", 32'(idle_out), 32'd1);
    model_clear();
    if (flush) for (int k = 0; k < 4; k++) fq[k].delete();
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    logic [3:0]  pl [8];
    logic        ovl [8];
    logic [11:0] odl [8];
    logic [1:0]  ocl [8];
    int ord [$];
    int pcy [$];
    int npop, nov, found, k;
    logic en_r;
`ifdef QOS_RD_STRICT_PRIO_EN
    int exp_ord [5] = '{0, 0, 0, 1, 1};
    int exp_03  [4] = '{0, 0, 0, 3};
`else
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int exp_03  [4] = '{0, 3, 0, 3};
`endif
    passed = 0; total = 0; cyc = 0;
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; fifo_empty = 4'hF;
    fifo_data0 = '0; fifo_data1 = '0; fifo_data2 = '0; fifo_data3 = '0;
    for (int i = 0; i < 4; i++) rdata[i] = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("init_pop", 32'(pop), 32'd0);
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_out_data", 32'(out_data), 32'd0);
    check("init_out_class", 32'(out_class), 32'd0);
    check("init_counts", 32'({rd_count0, rd_count1, rd_count2, rd_count3}), 32'd0);
    check("init_idle", 32'(idle_out), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Two words on class 2: pops at relative cycles 1,2, outputs at 3,4.
    fq[2].push_back(12'h0A5);
    fq[2].push_back(12'h0A6);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b1);
      pl[c] = last_pop; ovl[c] = last_ov; odl[c] = last_od; ocl[c] = last_oc;
    end
    check("a_pop0", 32'(pl[0]), 32'h0);
    check("a_pop1", 32'(pl[1]), 32'h4);
    check("a_pop2", 32'(pl[2]), 32'h4);
    check("a_ov2", 32'(ovl[2]), 32'd0);
    check("a_out3", 32'({ovl[3], ocl[3], odl[3]}), 32'({1'b1, 2'd2, 12'h0A5}));
    check("a_out4", 32'({ovl[4], ocl[4], odl[4]}), 32'({1'b1, 2'd2, 12'h0A6}));
    check("a_ov5", 32'(ovl[5]), 32'd0);
    check("a_idle", 32'(idle_out), 32'd1);

    // All classes loaded, sink always ready.
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) for (int i = 0; i < 3; i++) fq[c].push_back(word(c, i));
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) if (last_pop[i]) begin ord.push_back(i); pcy.push_back(c); end
    end
    check("b_npops", 32'(ord.size()), 32'd12);
    for (int i = 0; i < 5; i++) check("b_order", 32'((i < ord.size()) ? ord[i] : -1), 32'(exp_ord[i]));
    check("b_b2b", 32'((pcy.size() >= 5) ? pcy[4] - pcy[0] : -1), 32'd4);

    // Sink stalls: only two words may be outstanding.
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) for (int i = 0; i < 4; i++) fq[c].push_back(word(c, i));
    npop = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0);
      if (last_pop != 0) npop++;
    end
    check("c_stall_pops", 32'(npop), 32'd2);
    check("c_hold", 32'({last_ov, last_od}), 32'({1'b1, word(0, 0)}));
    for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
    check("c_valid_before_rst", 32'(last_ov), 32'd1);
    do_reset(1'b0);
    nov = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1);
      if (last_ov) nov++;
    end
    check("c_no_out_after_rst", 32'(nov), 32'd0);

    // Enable dropped right after a pop: in-flight word drains, then idle.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) fq[1].push_back(word(1, i));
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      step(1'b1, 1'b1);
      if (last_pop != 0) found = 1;
    end
    check("d_first_pop", 32'(found), 32'd1);
    npop = 0; nov = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1);
      if (last_pop != 0) npop++;
      if (last_ov) nov++;
    end
    check("d_drain_pops", 32'(npop), 32'd0);
    check("d_drain_words", 32'(nov), 32'd1);
    check("d_idle", 32'(idle_out), 32'd1);

    // Counter wrap: 33 pops of class 1.
    do_reset(1'b1);
    for (int i = 0; i < 33; i++) fq[1].push_back(12'(i));
    for (int c = 0; c < 40; c++) step(1'b1, 1'b1);
    check("e_fifo_drained", 32'(fq[1].size()), 32'd0);
    check("e_wrap", 32'(rd_count1), 32'd1);

    // Classes 0 and 3 loaded.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      fq[0].push_back(word(0, i));
      fq[3].push_back(word(3, i));
    end
    ord.delete();
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) if (last_pop[i]) ord.push_back(i);
    end
    for (int i = 0; i < 4; i++) check("g_order", 32'((i < ord.size()) ? ord[i] : -1), 32'(exp_03[i]));

    // Random traffic.
    do_reset(1'b1);
    en_r = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 99) < 25) begin
          k = $urandom_range(0, 3);
          if (fq[k].size() < 6) fq[k].push_back(12'($urandom));
        end
      end
      if ($urandom_range(0, 29) == 0) en_r = ~en_r;
      step(en_r, $urandom_range(0, 99) < 70);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
